// File: rtl/bu2020_data_memory.sv
// BU2020 data memory: 4096 x 16 storage on the MEM-stage bus with a
// combinational read port, a clocked write port and a two-beat burst
// engine for double reads/writes at consecutive addresses.
module bu2020_data_memory #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Memory_addressbus,
  input  logic [DATA_W-1:0] Memory_incoming_data_bus,
  input  logic              Memory_writemode,
  input  logic              doubleRead,
  input  logic              doubleWrite,
  output logic [DATA_W-1:0] Memory_databus,
  output logic              busy,
  output logic              burst_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] burst_addr;
  logic [ADDR_W-1:0] burst_addr_next;
  logic              burst_is_write;
  logic              burst_is_write_next;
  logic              burst_err_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  // Storage is deliberately not reset; contents are undefined until written.
  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state, burst bookkeeping and port-address selection.
  always_comb begin
    state_next          = IDLE;
    burst_addr_next     = burst_addr;
    burst_is_write_next = burst_is_write;
    burst_err_next      = burst_err;
    rd_addr             = Memory_addressbus;
    wr_addr             = Memory_addressbus;
    wr_en               = 1'b0;

    case (state)
      IDLE: begin
        wr_en = Memory_writemode;
        if (Memory_writemode) begin
          // Only doubleWrite opens a write burst; a doubleRead here is a conflict.
          if (doubleWrite) begin
            state_next          = BEAT2;
            burst_addr_next     = Memory_addressbus + ADDR_W'(1);
            burst_is_write_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
          if (doubleRead) begin
            burst_err_next = 1'b1;
          end else begin
            burst_err_next = burst_err;
          end
        end else begin
          // doubleWrite alone in read mode is just a single read, no error.
          if (doubleRead) begin
            state_next          = BEAT2;
            burst_addr_next     = Memory_addressbus + ADDR_W'(1);
            burst_is_write_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
          if (doubleRead && doubleWrite) begin
            burst_err_next = 1'b1;
          end else begin
            burst_err_next = burst_err;
          end
        end
      end
      BEAT2: begin
        // Bus address, mode and strobes are ignored on the second beat.
        rd_addr    = burst_addr;
        wr_addr    = burst_addr;
        wr_en      = burst_is_write;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any burst in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      burst_addr     <= {ADDR_W{1'b0}};
      burst_is_write <= 1'b0;
      burst_err      <= 1'b0;
    end else begin
      state          <= state_next;
      burst_addr     <= burst_addr_next;
      burst_is_write <= burst_is_write_next;
      burst_err      <= burst_err_next;
    end
  end

  // Clocked write port; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= Memory_incoming_data_bus;
    end
  end

  // Combinational read returns pre-edge contents for a same-cycle write.
  assign Memory_databus = mem[rd_addr];

  // busy decodes the state register, so it falls with the async reset.
  assign busy = (state == BEAT2);

endmodule

// File: doc/bu2020_data_memory.md
# bu2020_data_memory

Data-memory block on the BU2020 core's MEM-stage bus. It consumes the address, write data, write-enable and double-access strobes the MEM stage drives, and returns read data on the same bus. It provides 4096 x 16-bit storage with combinational read and clocked write. A two-beat burst engine serves double reads and double writes at consecutive addresses.

## Interface
- ADDR_W, 12, address width in words.
- DATA_W, 16, word width.
- DEPTH, 4096, number of words; always equals 2**ADDR_W.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- Memory_addressbus  input  ADDR_W  word address from the MEM stage.
- Memory_incoming_data_bus  input  DATA_W  write data from the MEM stage.
- Memory_writemode  input  1  1 = write, 0 = read.
- doubleRead  input  1  request a two-beat read.
- doubleWrite  input  1  request a two-beat write.
- Memory_databus  output  DATA_W  read data, combinational.
- busy  output  1  high while the second beat is in progress.
- burst_err  output  1  sticky flag for a conflicting request.

## Operation
- FSM states: IDLE and BEAT2. Internal registers: burst_addr (ADDR_W), burst_is_write (1).
- IDLE, read (writemode=0):
  - Memory_databus = mem[Memory_addressbus].
  - doubleRead=1 latches burst_addr = Memory_addressbus+1, sets burst_is_write=0 and moves to BEAT2.
- IDLE, write (writemode=1):
  - mem[Memory_addressbus] is written from Memory_incoming_data_bus at the clock edge.
  - doubleWrite=1 latches burst_addr = address+1, sets burst_is_write=1 and moves to BEAT2.
- BEAT2:
  - Memory_addressbus, writemode and both strobes are ignored.
  - Read burst: Memory_databus = mem[burst_addr].
  - Write burst: mem[burst_addr] is written from the current Memory_incoming_data_bus at the edge.
  - The FSM always returns to IDLE after one cycle.
- Address arithmetic: burst_addr = (addr+1) mod DEPTH, so 0xFFF wraps to 0x000.
- Strobes effective only with matching mode:
  - doubleWrite with writemode=0 is a single read.
  - doubleRead with writemode=1 is a single write and sets burst_err.
- doubleRead and doubleWrite both high: the request is decided by writemode alone using the rules above. burst_err is set.
- Read during write, same cycle and same address: Memory_databus shows the old contents. The new value is visible from the next cycle.
- Memory contents are not cleared by reset. They are undefined until written.

## Timing
- Reset values: state=IDLE, busy=0, burst_err=0, burst_addr=0, burst_is_write=0.
- During reset, Memory_databus = mem[Memory_addressbus], and no write occurs.
- Read latency: 0 cycles, combinational from the address (IDLE) or from burst_addr (BEAT2).
- Write latency: 1 edge. Data is visible on the cycle after the edge.
- A burst occupies exactly 2 cycles: the request cycle and BEAT2. busy is high in BEAT2 only.
- Back-to-back bursts: a new request is accepted in the first IDLE cycle after BEAT2. There is no dead cycle.
- Reset asserted in BEAT2 aborts the burst immediately. The second write is not performed, busy drops asynchronously and the FSM is in IDLE.
- burst_err clears only on reset.

## Test plan
- Single write/read:
  - Write 0xBEEF to 0x010, then read 0x010 the next cycle: Memory_databus=0xBEEF.
  - In the write cycle itself, Memory_databus shows the prior value.
- Double write then double read:
  - doubleWrite at 0x020 with 0x1111, then 0x2222 on beat 2, while the address bus is driven to 0x555: mem[0x020]=0x1111, mem[0x021]=0x2222, mem[0x555] unchanged, busy high for 1 cycle.
  - doubleRead at 0x020 returns 0x1111 then 0x2222.
- Wrap-around: doubleWrite at 0xFFF with 0xAAAA then 0x5555 writes mem[0xFFF]=0xAAAA and mem[0x000]=0x5555.
- Conflicts:
  - doubleRead with writemode=1 at 0x030, data 0x0042: single write of 0x0042, busy stays 0, burst_err=1 until rst.
  - doubleWrite with writemode=0 performs a single read and leaves burst_err unchanged.
- Reset mid-burst:
  - doubleWrite at 0x040 with 0x1234, then rst pulsed during BEAT2 with data 0x9999: mem[0x040]=0x1234, mem[0x041] unchanged, busy=0 immediately.
  - The next cycle accepts a new request.
- Back-to-back: doubleRead at 0x100 immediately followed by doubleRead at 0x200 yields four consecutive beats, mem[0x100], mem[0x101], mem[0x200], mem[0x201], with busy pattern 0,1,0,1.
